// File: rtl/branch_ex.sv
// branch_ex: branch/jump resolution with redirect handshake, link writeback and taken counter
module branch_ex #(
  parameter logic [15:0] CNT_MAX = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_nop_in,
  input  logic        is_jmp_in,
  input  logic        is_imm_type_in,
  input  logic        zero_ext_in,
  input  logic [1:0]  op_in,
  input  logic [4:0]  rs1_in,
  input  logic [4:0]  rs2_in,
  input  logic [4:0]  rd_in,
  input  logic [21:0] imm_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        redirect_ready,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [15:0] taken_count
);
  typedef enum logic [1:0] {IDLE, WAIT_RDY, FLUSH} state_t;
  state_t state, next_state;
  logic [31:0] off, target;
  logic eq, lt, taken, valid, unused;
  assign unused = ^{rs1_in, rs2_in};
  assign off = {{8{imm_in[21]}}, imm_in, 2'b00};
  assign valid = (state == IDLE) && !is_nop_in;
  assign eq = rs1_data == rs2_data;
  assign lt = zero_ext_in ? rs1_data < rs2_data : $signed(rs1_data) < $signed(rs2_data);
  assign taken = is_jmp_in | (op_in[1] ? lt ^ op_in[0] : eq ^ op_in[0]);
  assign target = (is_jmp_in && !is_imm_type_in) ? (rs1_data + off) & ~32'd3 : pc_in + off;
  assign stall = state == WAIT_RDY;
  assign flush = state == FLUSH;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next_state;
  // next state: taken instruction waits for fetch, accepted redirect flushes once
  always_comb begin
    next_state = state;
    if (state == IDLE) next_state = (valid && taken) ? WAIT_RDY : IDLE;
    else if (state == WAIT_RDY) next_state = (redirect_valid && redirect_ready) ? FLUSH : WAIT_RDY;
    else next_state = IDLE;
  end
  // registered outputs: redirect request, link write and saturating taken counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc <= 32'd0;
      wb_en <= 1'b0;
      wb_rd <= 5'd0;
      wb_data <= 32'd0;
      taken_count <= 16'd0;
    end else begin
      wb_en <= 1'b0;
      if (valid) begin
        if (is_jmp_in && rd_in != 5'd0) begin
          wb_en <= 1'b1;
          wb_rd <= rd_in;
          wb_data <= pc_in + 32'd4;
        end
        if (taken) begin
          redirect_valid <= 1'b1;
          redirect_pc <= target;
          taken_count <= (taken_count == CNT_MAX) ? taken_count : taken_count + 16'd1;
        end
      end else if (state == WAIT_RDY && redirect_valid && redirect_ready) redirect_valid <= 1'b0;
    end
endmodule

// File: tb/tb_branch_ex.sv
// tb_branch_ex: randomized and directed checks of branch_ex against a behavioural model
module tb_branch_ex;
  localparam logic [15:0] CNT_MAX = 16'd300;
  logic clk = 1'b0, rst = 1'b0;
  logic is_nop_in, is_jmp_in, is_imm_type_in, zero_ext_in, redirect_ready;
  logic [1:0] op_in;
  logic [4:0] rs1_in, rs2_in, rd_in;
  logic [21:0] imm_in;
  logic [31:0] pc_in, rs1_data, rs2_data;
  logic stall, flush, redirect_valid, wb_en;
  logic [31:0] redirect_pc, wb_data;
  logic [4:0] wb_rd;
  logic [15:0] taken_count;
  int errors = 0, checks = 0;
  bit m_busy = 0, m_flush = 0, m_wb_en = 0;
  logic [31:0] m_pc = 0, m_wb_data = 0;
  logic [4:0] m_wb_rd = 0;
  int m_cnt = 0;

  branch_ex #(.CNT_MAX(CNT_MAX)) dut (
    .clk(clk), .rst(rst), .is_nop_in(is_nop_in), .is_jmp_in(is_jmp_in),
    .is_imm_type_in(is_imm_type_in), .zero_ext_in(zero_ext_in), .op_in(op_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .imm_in(imm_in), .pc_in(pc_in),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .redirect_ready(redirect_ready),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sx(input logic [31:0] v);
    return v[31] ? longint'(v) - 64'sh100000000 : longint'(v);
  endfunction

  // behavioural model: what the outputs must be after each edge
  initial forever begin : model
    longint o;
    logic [31:0] t;
    bit tk, lt;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_busy = 0; m_flush = 0; m_wb_en = 0; m_pc = 0; m_wb_rd = 0; m_wb_data = 0; m_cnt = 0;
    end else begin
      m_wb_en = 0;
      if (m_flush) m_flush = 0;
      else if (m_busy) begin
        if (redirect_ready) begin m_busy = 0; m_flush = 1; end
      end else if (!is_nop_in) begin
        o = (imm_in[21] ? longint'(imm_in) - 64'sh400000 : longint'(imm_in)) * 4;
        lt = zero_ext_in ? longint'(rs1_data) < longint'(rs2_data) : sx(rs1_data) < sx(rs2_data);
        if (op_in == 2'd0) tk = rs1_data == rs2_data;
        else if (op_in == 2'd1) tk = rs1_data != rs2_data;
        else if (op_in == 2'd2) tk = lt;
        else tk = !lt;
        if (is_jmp_in) tk = 1;
        if (is_jmp_in && !is_imm_type_in) begin
          t = 32'(longint'(rs1_data) + o);
          t = t - t % 4;
        end else t = 32'(longint'(pc_in) + o);
        if (is_jmp_in && rd_in != 0) begin
          m_wb_en = 1; m_wb_rd = rd_in; m_wb_data = 32'(longint'(pc_in) + 4);
        end
        if (tk) begin
          m_busy = 1; m_pc = t;
          if (m_cnt < int'(CNT_MAX)) m_cnt++;
        end
      end
    end
  end

  // compare every cycle on the falling edge
  initial forever begin
    @(negedge clk);
    chk("stall", stall, m_busy);
    chk("flush", flush, m_flush);
    chk("redirect_valid", redirect_valid, m_busy);
    chk("redirect_pc", redirect_pc, m_pc);
    chk("wb_en", wb_en, m_wb_en);
    chk("wb_rd", wb_rd, m_wb_rd);
    chk("wb_data", wb_data, m_wb_data);
    chk("taken_count", taken_count, m_cnt);
  end

  task automatic instr(input bit jmp, input bit immt, input bit zx, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                       input logic [21:0] imm, input logic [4:0] rd);
    is_nop_in = 0; is_jmp_in = jmp; is_imm_type_in = immt; zero_ext_in = zx; op_in = op;
    rs1_data = a; rs2_data = b; pc_in = pc; imm_in = imm; rd_in = rd;
    rs1_in = 5'($urandom); rs2_in = 5'($urandom);
  endtask

  task automatic nop();
    is_nop_in = 1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    is_nop_in = 1; is_jmp_in = 0; is_imm_type_in = 0; zero_ext_in = 0; op_in = 0;
    rs1_in = 0; rs2_in = 0; rd_in = 0; imm_in = 0; pc_in = 0; rs1_data = 0; rs2_data = 0;
    redirect_ready = 0;
    #1 rst = 1;
    step(1);
    chk("reset_rv", redirect_valid, 0);
    chk("reset_pc", redirect_pc, 0);
    chk("reset_cnt", taken_count, 0);
    rst = 0;
    step(1);
    // BEQ signed, fetch immediately ready
    redirect_ready = 1;
    instr(0, 0, 0, 2'b00, 5, 5, 32'h100, 22'd3, 0);
    step(1); nop();
    chk("beq_rv", redirect_valid, 1);
    chk("beq_pc", redirect_pc, 32'h10C);
    chk("beq_stall", stall, 1);
    step(1);
    chk("beq_flush", flush, 1);
    chk("beq_flush_stall", stall, 0);
    step(1);
    chk("beq_flush_end", flush, 0);
    chk("beq_cnt", taken_count, 1);
    // BLT signed taken, unsigned not taken
    instr(0, 0, 0, 2'b10, 32'hFFFFFFFF, 1, 32'h200, 22'd0, 0);
    step(1); nop();
    chk("blt_s_rv", redirect_valid, 1);
    step(2);
    instr(0, 0, 1, 2'b10, 32'hFFFFFFFF, 1, 32'h200, 22'd0, 0);
    step(1); nop();
    chk("blt_u_rv", redirect_valid, 0);
    chk("blt_u_stall", stall, 0);
    chk("blt_u_cnt", taken_count, 2);
    // register jump with link
    instr(1, 0, 0, 2'b00, 32'h2003, 0, 32'h40, 22'd1, 5);
    step(1); nop();
    chk("jalr_pc", redirect_pc, 32'h2004);
    chk("jalr_wb_en", wb_en, 1);
    chk("jalr_wb_rd", wb_rd, 5);
    chk("jalr_wb_data", wb_data, 32'h44);
    step(1);
    chk("jalr_wb_once", wb_en, 0);
    step(1);
    // backpressure with a wrong-path jump held on the inputs
    redirect_ready = 0;
    instr(0, 1, 0, 2'b01, 7, 8, 32'h1000, 22'h3FFFFF, 0);
    step(1);
    instr(1, 0, 0, 2'b00, 32'h5000, 0, 32'h3000, 22'h10, 7);
    for (int i = 0; i < 4; i++) begin
      chk("bp_stall", stall, 1);
      chk("bp_pc", redirect_pc, 32'hFFC);
      chk("bp_wb_en", wb_en, 0);
      if (i < 3) step(1);
    end
    redirect_ready = 1;
    step(1);
    chk("bp_flush", flush, 1);
    nop();
    step(1);
    chk("bp_flush_once", flush, 0);
    chk("bp_cnt", taken_count, 4);
    // nop with jump fields, jump without link, wrapping target
    instr(1, 1, 0, 2'b00, 0, 0, 32'h80, 22'd2, 3);
    nop();
    step(1);
    chk("nop_rv", redirect_valid, 0);
    chk("nop_wb_en", wb_en, 0);
    instr(1, 1, 0, 2'b00, 0, 0, 32'h80, 22'd2, 0);
    step(1); nop();
    chk("j_rd0_rv", redirect_valid, 1);
    chk("j_rd0_pc", redirect_pc, 32'h88);
    chk("j_rd0_wb_en", wb_en, 0);
    step(2);
    instr(1, 1, 0, 2'b00, 0, 0, 32'hFFFFFFF0, 22'd8, 0);
    step(1); nop();
    chk("wrap_pc", redirect_pc, 32'h10);
    step(2);
    // reset while waiting for fetch
    redirect_ready = 0;
    instr(0, 1, 0, 2'b00, 9, 9, 32'h500, 22'd4, 0);
    step(1); nop();
    chk("rw_rv", redirect_valid, 1);
    #2 rst = 1;
    #1;
    chk("rw_async_rv", redirect_valid, 0);
    chk("rw_async_stall", stall, 0);
    chk("rw_async_cnt", taken_count, 0);
    #1 rst = 0;
    redirect_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rw_no_flush", flush, 0);
      chk("rw_cnt", taken_count, 0);
    end
    // randomized traffic
    repeat (600) begin
      step(1);
      redirect_ready = ($urandom % 2) == 0;
      instr(($urandom % 3) == 0, $urandom % 2, $urandom % 2, 2'($urandom),
            $urandom, 0, $urandom, 22'($urandom), 5'($urandom));
      rs2_data = ($urandom % 3 == 0) ? rs1_data : $urandom;
      if ($urandom % 4 == 0) nop();
    end
    step(1); nop(); redirect_ready = 1;
    step(3);
    // saturation of the taken counter
    repeat (int'(CNT_MAX) + 5) begin
      instr(0, 1, 0, 2'b00, 1, 1, 32'h700, 22'd4, 0);
      step(1); nop();
      step(2);
    end
    chk("sat_cnt", taken_count, CNT_MAX);
    chk("sat_model", m_cnt, CNT_MAX);
    instr(0, 1, 0, 2'b00, 1, 1, 32'h700, 22'd4, 0);
    step(1); nop();
    chk("sat_hold_rv", redirect_valid, 1);
    chk("sat_hold_cnt", taken_count, CNT_MAX);
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
